// File: rtl/step_motor_pkg.sv
// Shared definitions for the stepper sequencer.
//   state_t     : sequencer state (IDLE, RUN)
//   PHASE_TABLE : phase index -> {AX, AY, AE, BX, BY, BE}
//   MIN_PERIOD  : shortest allowed step period in clock cycles
package step_motor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_PERIOD = 2;

  // Bridge codes, ordered {X, Y, E}.
  localparam logic [2:0] BR_POS = 3'b101;
  localparam logic [2:0] BR_NEG = 3'b011;
  localparam logic [2:0] BR_OFF = 3'b000;

  // Eight half-step phases; even indices drive one winding,
  // odd indices drive both windings.
  localparam logic [7:0][5:0] PHASE_TABLE = {
    {BR_POS, BR_NEG},  // 7: A+ / B-
    {BR_OFF, BR_NEG},  // 6: off / B-
    {BR_NEG, BR_NEG},  // 5: A- / B-
    {BR_NEG, BR_OFF},  // 4: A- / off
    {BR_NEG, BR_POS},  // 3: A- / B+
    {BR_OFF, BR_POS},  // 2: off / B+
    {BR_POS, BR_POS},  // 1: A+ / B+
    {BR_POS, BR_OFF}   // 0: A+ / off
  };

endpackage

// File: rtl/step_phase_decode.sv
// Combinational phase decoder.
//   index    : 3-bit phase index
//   energize : 1 = drive the windings, 0 = all bridges off
//   drive    : {AX, AY, AE, BX, BY, BE}
module step_phase_decode
  import step_motor_pkg::*;
(
  input  logic [2:0] index,
  input  logic       energize,
  output logic [5:0] drive
);

  assign drive = energize ? PHASE_TABLE[index] : 6'b000000;

endmodule

// File: rtl/step_motor_driver.sv
// Step/direction sequencer for one two-phase bipolar stepper channel.
//   clock, reset          : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready = !busy && !stop)
//   cmd_steps, cmd_dir,
//   cmd_half, cmd_period  : move length, direction, half/full mode, cycles per step
//   stop                  : abort the current move
//   hold_en               : keep windings energized while idle
//   busy, done, aborted   : move status (done is a one-cycle pulse)
//   position              : signed position in half-step units
//   AX, AY, BX, BY, AE, BE: registered H-bridge drives
module step_motor_driver
  import step_motor_pkg::*;
#(
  parameter int STEP_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int POS_WIDTH    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STEP_WIDTH-1:0]   cmd_steps,
  input  logic                    cmd_dir,
  input  logic                    cmd_half,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  input  logic                    stop,
  input  logic                    hold_en,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [POS_WIDTH-1:0]    position,
  output logic                    AX,
  output logic                    AY,
  output logic                    BX,
  output logic                    BY,
  output logic                    AE,
  output logic                    BE
);

  state_t                  state;
  logic [2:0]              index;
  logic [PERIOD_WIDTH-1:0] timer;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [STEP_WIDTH-1:0]   remaining;
  logic                    dir_q;
  logic                    half_q;
  logic                    zero_pend;
  logic [5:0]              drive_q;

  logic                    accept;
  logic [PERIOD_WIDTH-1:0] eff_period;
  logic                    step_edge;
  logic [2:0]              step_mag;
  logic [2:0]              index_step;
  logic [2:0]              index_next;
  logic [POS_WIDTH-1:0]    pos_delta;
  logic [5:0]              decode_drive;

  assign busy      = (state == RUN);
  assign cmd_ready = !busy && !stop;
  assign accept    = cmd_valid && cmd_ready;

  assign eff_period = (cmd_period < PERIOD_WIDTH'(MIN_PERIOD))
                      ? PERIOD_WIDTH'(MIN_PERIOD) : cmd_period;

  // stop outranks a coinciding step edge.
  assign step_edge = busy && !stop && (timer == '0);

  // Full-step from an odd index jumps two phases; from an even index it
  // moves one phase to realign onto the two-winding (odd) phases.
  assign step_mag   = (!half_q && index[0]) ? 3'd2 : 3'd1;
  assign index_step = dir_q ? (index - step_mag) : (index + step_mag);
  assign index_next = step_edge ? index_step : index;
  assign pos_delta  = POS_WIDTH'(step_mag);

  // Energize uses the pre-edge busy, so drives follow busy/hold_en one
  // edge late while a step shows its new phase on the step edge itself.
  step_phase_decode u_decode (
    .index    (index_next),
    .energize (busy || hold_en),
    .drive    (decode_drive)
  );

  assign {AX, AY, AE, BX, BY, BE} = drive_q;

  // NOTE: every register here is sequential state, so all assignments in
  // this block are non-blocking; blocking ones would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      index     <= 3'd0;
      timer     <= '0;
      period_q  <= PERIOD_WIDTH'(MIN_PERIOD);
      remaining <= '0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      zero_pend <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      position  <= '0;
      drive_q   <= 6'b000000;
    end else begin
      done      <= 1'b0;
      zero_pend <= 1'b0;
      index     <= index_next;
      drive_q   <= decode_drive;
      case (state)
        IDLE: begin
          // A zero-length command completes one edge after its accept.
          if (zero_pend) done <= 1'b1;
          if (accept) begin
            aborted   <= 1'b0;
            dir_q     <= cmd_dir;
            half_q    <= cmd_half;
            period_q  <= eff_period;
            timer     <= eff_period - 1'b1;
            remaining <= cmd_steps;
            if (cmd_steps == '0) zero_pend <= 1'b1;
            else                 state     <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (step_edge) begin
            position  <= dir_q ? (position - pos_delta) : (position + pos_delta);
            timer     <= period_q - 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == STEP_WIDTH'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/step_motor_driver.md
Name: step_motor_driver

Overview:
Step/direction sequencer for one two-phase bipolar stepper channel. Accepts move commands (step count, direction, full/half mode, step period) over a valid/ready handshake. Produces the six H-bridge drive signals AX, AY, BX, BY, AE, BE. These feed directly into the board pin-mapping top, which routes them to the PIO26 header pins. One instance is used per motor channel (0..3).

Parameters:
STEP_WIDTH, 16, width of cmd_steps (steps per command)
PERIOD_WIDTH, 16, width of cmd_period (clock cycles per step)
POS_WIDTH, 32, width of signed position counter (half-step units)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command can be accepted; = !busy && !stop
cmd_steps  input  STEP_WIDTH  number of steps to move
cmd_dir  input  1  0 = forward (phase index increments), 1 = reverse
cmd_half  input  1  1 = half-step, 0 = full-step (two-phase-on)
cmd_period  input  PERIOD_WIDTH  clock cycles between steps
stop  input  1  abort current move
hold_en  input  1  keep windings energized while idle
busy  output  1  move in progress
done  output  1  one-cycle pulse at move completion or abort
aborted  output  1  last move ended by stop; sticky until next accept
position  output  POS_WIDTH  signed position, half-step units
AX, AY, BX, BY, AE, BE  output  1 each  registered bridge drives

Behaviour:
- Reset: phase index 0; state IDLE; busy=0, done=0, aborted=0, position=0; all six drives 0.
- Phase table (index: A bridge / B bridge): 0:A+/off, 1:A+/B+, 2:off/B+, 3:A-/B+, 4:A-/off, 5:A-/B-, 6:off/B-, 7:A+/B-.
- Bridge encoding: A+ means AX=1, AY=0, AE=1. A- means AX=0, AY=1, AE=1. off means AX=AY=AE=0. B bridge is identical using BX/BY/BE.
- Energized = busy || hold_en. When not energized, all six drives are 0 and the phase index is retained.
- Drives are registered and reflect the phase index and energize state one edge after those change. Exception: a step edge updates the index and drives on the same edge.
- Handshake: accept occurs at an edge where cmd_valid && cmd_ready.
- On accept: latch steps, dir, mode and period; clear aborted; go to RUN, busy=1.
- Period clamp: an effective period below 2 is clamped to 2.
- cmd_steps=0: no RUN. done pulses on the edge after accept, busy stays 0, no phase or position change.
- RUN timing: the timer counts from accept. The step edges are at accept+P, accept+2P, and so on, where P is the effective period.
- Each step edge: index moves ±1 (half mode) or ±2 mod 8 (full mode); remaining count decrements; position updates by the same signed delta.
- Full-mode alignment: if the index is even at a step edge, that step moves ±1 onto an odd index and position changes by ±1.
- Wrap-around: the index wraps mod 8; position wraps two's complement.
- Completion: the final step edge also sets busy=0 and done=1, returning to IDLE. A new command can be accepted on the next edge.
- stop in RUN: on the next edge go to IDLE, busy=0, done=1, aborted=1.
- stop vs step: if stop coincides with a step edge, stop wins and no step is taken.
- stop in IDLE: no effect except that cmd_ready is deasserted.
- Reset mid-run: immediately restores reset values, regardless of state.

Decomposition:
- Shared package step_motor_pkg:
  - state enum {IDLE, RUN}
  - 8-entry phase table constant (index → {AX, AY, AE, BX, BY, BE})
  - MIN_PERIOD=2
- One combinational sub-module, step_phase_decode: 3-bit index plus energize input → six drive bits. The registers stay in step_motor_driver.

Test Plan:
1. Half-step forward from reset: steps=4, dir=0, half=1, period=3. Index goes 1,2,3,4 at accept+3/6/9/12. done=1 and busy=0 at accept+12; position=4. Drives at index 4: AX=0, AY=1, AE=1, BE=0.
2. Full-step forward from index 0: steps=3, half=0, period=5. Indices are 1, 3, 5 (first step aligns by +1). position=5. Each step has both AE=1 and BE=1.
3. Reverse wrap from index 0: steps=2, dir=1, half=1, period=2. Indices are 7 then 6; position=0xFFFFFFFE. At index 6: BX=0, BY=1, BE=1, AE=0.
4. Abort: steps=10, period=4. Assert stop at accept+9 (after 2 steps). Next edge gives done pulse, aborted=1, position=2, index 2 held. Drives are 0 if hold_en=0, or the index 2 pattern if hold_en=1.
5. Degenerate commands:
   - steps=0: done pulses at accept+1; drives and position unchanged.
   - period=0 with steps=1: step occurs at accept+2.
   - stop and cmd_valid together in IDLE: no accept.
6. Reset mid-run (steps=100, period=2, reset asserted at accept+7): on the next edge all drives 0, busy=0, position=0, cmd_ready=1.
